// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_pkg: access encodings and defaults for the data-memory arbiter   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package dmem_pkg;

    localparam int unsigned MEM_BYTES_DEFAULT = 1024;
    localparam int unsigned MAX_WAIT_DEFAULT  = 8;

    typedef enum logic [1:0] {
        ST_SB = 2'b00,
        ST_SH = 2'b01,
        ST_SW = 2'b10
    } store_type_e;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b011,
        LD_LHU = 3'b100
    } load_type_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_TYPE  = 2'b01,
        ERR_ALIGN = 2'b10,
        ERR_RANGE = 2'b11
    } err_code_e;

    typedef enum logic [0:0] {
        ARB       = 1'b0,
        DBG_FORCE = 1'b1
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/dmem_access_check.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_access_check: flags illegal type, misaligned or out-of-range     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module dmem_access_check
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
    input  logic        we,
    input  logic [1:0]  store_type,
    input  logic [2:0]  load_type,
    input  logic [31:0] addr,
    output logic        legal
);

    err_code_e err;

    always_comb begin
        err = ERR_NONE;
        if (we) begin
            case (store_type)
                ST_SB:   err = ERR_NONE;
                ST_SH:   if (addr[0]) err = ERR_ALIGN;
                ST_SW:   if (addr[1:0] != 2'b00) err = ERR_ALIGN;
                default: err = ERR_TYPE;
            endcase
        end else begin
            case (load_type)
                LD_LB, LD_LBU: err = ERR_NONE;
                LD_LH, LD_LHU: if (addr[0]) err = ERR_ALIGN;
                LD_LW:         if (addr[1:0] != 2'b00) err = ERR_ALIGN;
                default:       err = ERR_TYPE;
            endcase
        end
        if ((err == ERR_NONE) && (addr >= MEM_BYTES)) err = ERR_RANGE;
        legal = (err == ERR_NONE);
    end

endmodule
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_port_arbiter: core/debug arbitration onto one data memory unit   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module dmem_port_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT,
    parameter int unsigned MAX_WAIT  = MAX_WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [1:0]  c_store_type,
    input  logic [2:0]  c_load_type,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic        c_gnt,
    output logic        c_stall,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,
    output logic        c_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_store_type,
    input  logic [2:0]  d_load_type,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        m_mem_read,
    output logic        m_mem_write,
    output logic [1:0]  m_store_type,
    output logic [2:0]  m_load_type,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    localparam int unsigned    WCW        = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT - 1);

    arb_state_e     state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           c_rvalid_q, c_rvalid_d, c_err_q, c_err_d;
    logic           d_rvalid_q, d_rvalid_d, d_err_q, d_err_d;
    logic [31:0]    c_rdata_q, c_rdata_d, d_rdata_q, d_rdata_d;

    logic           force_dbg, grant, legal, sel_we;
    logic [1:0]     sel_st;
    logic [2:0]     sel_lt;
    logic [31:0]    sel_addr, sel_wdata;

    // Grants are gated by rst so nothing reaches memory while reset is held.
    always_comb begin
        force_dbg = d_req && ((state_q == DBG_FORCE) || (wait_cnt_q == WAIT_LIMIT));
        c_gnt     = !rst && c_req && !force_dbg;
        d_gnt     = !rst && d_req && (force_dbg || !c_req);
        c_stall   = c_req && !c_gnt;
        grant     = c_gnt || d_gnt;
        sel_we    = d_gnt ? d_we         : c_we;
        sel_st    = d_gnt ? d_store_type : c_store_type;
        sel_lt    = d_gnt ? d_load_type  : c_load_type;
        sel_addr  = d_gnt ? d_addr       : c_addr;
        sel_wdata = d_gnt ? d_wdata      : c_wdata;
    end

    dmem_access_check #(
        .MEM_BYTES (MEM_BYTES)
    ) u_access_check (
        .we         (sel_we),
        .store_type (sel_st),
        .load_type  (sel_lt),
        .addr       (sel_addr),
        .legal      (legal)
    );

    always_comb begin
        m_mem_read   = grant && legal && !sel_we;
        m_mem_write  = grant && legal && sel_we;
        m_store_type = grant ? sel_st    : 2'b00;
        m_load_type  = grant ? sel_lt    : 3'b000;
        m_addr       = grant ? sel_addr  : 32'h0;
        m_wdata      = grant ? sel_wdata : 32'h0;
    end

    // Any dbg cycle that is not a loss (granted or idle) restarts the count.
    always_comb begin
        wait_cnt_d = '0;
        if (d_req && !d_gnt) begin
            wait_cnt_d = (wait_cnt_q == WAIT_LIMIT) ? WAIT_LIMIT : wait_cnt_q + WCW'(1);
        end
        state_d = ARB;
        if (d_req && !d_gnt && (wait_cnt_d == WAIT_LIMIT)) state_d = DBG_FORCE;

        c_rvalid_d = c_gnt && (!legal || !sel_we);
        c_err_d    = c_gnt && !legal;
        c_rdata_d  = (c_gnt && legal && !sel_we) ? m_rdata : 32'h0;
        d_rvalid_d = d_gnt && (!legal || !sel_we);
        d_err_d    = d_gnt && !legal;
        d_rdata_d  = (d_gnt && legal && !sel_we) ? m_rdata : 32'h0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB;
            wait_cnt_q <= '0;
            c_rvalid_q <= 1'b0;
            c_err_q    <= 1'b0;
            c_rdata_q  <= 32'h0;
            d_rvalid_q <= 1'b0;
            d_err_q    <= 1'b0;
            d_rdata_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            c_rvalid_q <= c_rvalid_d;
            c_err_q    <= c_err_d;
            c_rdata_q  <= c_rdata_d;
            d_rvalid_q <= d_rvalid_d;
            d_err_q    <= d_err_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign c_rvalid = c_rvalid_q;
    assign c_err    = c_err_q;
    assign c_rdata  = c_rdata_q;
    assign d_rvalid = d_rvalid_q;
    assign d_err    = d_err_q;
    assign d_rdata  = d_rdata_q;

endmodule
`default_nettype wire

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data memory unit (store datapath, 1 KB memory, load datapath) between two requesters.
  - Requester 0 is the pipeline MEM stage (core port).
  - Requester 1 is a debug/loader port (dbg port).
- Grants at most one access per cycle.
- Traps misaligned and out-of-range accesses before they reach memory.
- Returns read data through a registered response, one cycle after grant.
- Enforces a starvation bound so the dbg port is always eventually served.

Parameters:
- MEM_BYTES, 1024, addressable bytes; any access with addr >= MEM_BYTES is out of range.
- MAX_WAIT, 8, consecutive cycles a pending dbg request may lose to core before it is forced a grant.

Ports:
- clk  in  1  clock; memory writes and all state update on rising edge
- rst  in  1  asynchronous, active-high reset
- c_req  in  1  core request, held until c_gnt
- c_we  in  1  1=store, 0=load
- c_store_type  in  2  00=SB, 01=SH, 10=SW
- c_load_type  in  3  000=LB, 001=LH, 010=LW, 011=LBU, 100=LHU
- c_addr  in  32  byte address
- c_wdata  in  32  store data
- c_gnt  out  1  request accepted this cycle
- c_stall  out  1  c_req & ~c_gnt
- c_rvalid  out  1  response valid (loads and errors)
- c_rdata  out  32  load result
- c_err  out  1  with c_rvalid: misaligned or out-of-range
- d_req, d_we, d_store_type, d_load_type, d_addr, d_wdata  in  same as core
- d_gnt, d_rvalid, d_rdata, d_err  out  same as core
- m_mem_read  out  1  to data memory unit
- m_mem_write  out  1  to data memory unit
- m_store_type  out  2  to data memory unit
- m_load_type  out  3  to data memory unit
- m_addr  out  32  to data memory unit
- m_wdata  out  32  to data memory unit
- m_rdata  in  32  load-extended result from data memory unit (combinational from m_addr)

Behaviour:
- Reset, asynchronous: all gnt/rvalid/err = 0; rdata = 0; wait_cnt = 0; state = ARB.
  - Memory-side outputs are 0 whenever no grant.
  - Reset mid-transaction drops any pending response; a write is only committed if its clock edge precedes reset.
- Arbitration is combinational within the cycle.
  - Default: core wins when both request.
  - If wait_cnt == MAX_WAIT-1 and d_req, dbg wins.
- wait_cnt:
  - Increments when d_req & ~d_gnt, saturating at MAX_WAIT-1.
  - Clears when d_gnt or when ~d_req.
- Alignment and range check on the winner:
  - SW/LW require addr[1:0]==0; SH/LH/LHU require addr[0]==0.
  - Out of range: addr >= MEM_BYTES.
  - On violation: grant still asserted, m_mem_read = m_mem_write = 0, and the next cycle gives rvalid=1, err=1, rdata=0. This applies to both stores and loads.
- Legal store: m_mem_write=1 in the grant cycle, committed at that clock edge. No rvalid.
- Legal load: m_mem_read=1; m_rdata is captured at the edge; next cycle rvalid=1, err=0, rdata=captured value.
  - rvalid is a single-cycle pulse; the requester must take the data that cycle.
- Latency: store takes effect at the grant edge; load response arrives 1 cycle after grant.
- Back-to-back grants every cycle are allowed. A store followed immediately by a load to the same word returns the new data.
- Invalid load_type encodings (101-111) are treated as errors.
- State machine:
  - ARB: normal priority.
  - DBG_FORCE: entered when wait_cnt reaches MAX_WAIT-1 with d_req. Grants dbg for exactly one cycle, then returns to ARB.
  - If d_req drops while in DBG_FORCE, return to ARB with no grant.
- Simultaneous: c_req with a dbg force gives d_gnt=1, c_gnt=0, c_stall=1.

Decomposition:
- Package dmem_pkg: store_type and load_type encodings, error codes, MEM_BYTES default.
- Sub-module dmem_access_check: combinational; inputs are we, types and addr; output is legal. Instanced once on the muxed winner.

Test Plan:
1. Core SW addr 0x4, data 0xAABBCCDD, then core LW 0x4 → c_gnt each cycle; c_rvalid one cycle after LW grant with c_rdata=0xAABBCCDD, c_err=0.
2. Both request: core LB 0x8, dbg LW 0x4 → c_gnt=1, d_gnt=0, wait_cnt=1; next cycle dbg granted and d_rdata=0xAABBCCDD.
3. Core requests continuously for 10 cycles while dbg holds LW 0x4 → d_gnt on cycle 8 (MAX_WAIT) with c_stall=1 that cycle; core resumes the cycle after.
4. Core LW 0x6 and core SH 0x9 → each granted, no m_mem_read/m_mem_write pulse, c_rvalid=1 with c_err=1; memory word 0x4 unchanged.
5. Dbg SW 0x400 (MEM_BYTES) → d_err=1, no write; dbg load_type=3'b101 → d_err=1.
6. Assert rst in the cycle after a core LW grant → c_rvalid stays 0 and all outputs are 0; after release, a fresh LW 0x4 returns 0xAABBCCDD.
